// File: rtl/bf_loop_ctrl_pkg.sv
// Shared types and default widths for the butterfly loop-nest controller.
// The state enum is also used by benches to decode the debug state port.
package bf_loop_ctrl_pkg;

    localparam int BfCntW   = 8;
    localparam int BfLayerW = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_BF    = 3'd2,
        ST_LAYER = 3'd3,
        ST_DONE  = 3'd4
    } bf_ctrl_state_e;

endpackage

// File: rtl/bf_loop_ctrl.sv
// Sequencer for the register address unit: walks layers, groups and butterflies of an (I)NTT,
// strobing the index/shift controls and offering each butterfly to the datapath.
//
// Handshake: a butterfly transfers on a cycle where bf_valid_o && bf_ready_i. bf_valid_o does
// not wait for ready and stays high (with all strobes low) until the transfer happens.
module bf_loop_ctrl
    import bf_loop_ctrl_pkg::*;
#(
    parameter int CntW   = BfCntW,
    parameter int LayerW = BfLayerW
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              mode_i,
    input  logic [CntW-1:0]   cfg_m_i,
    input  logic [CntW-1:0]   cfg_groups_i,
    input  logic [LayerW-1:0] cfg_layers_i,
    output logic              bf_valid_o,
    input  logic              bf_ready_i,
    output logic              set_idx_o,
    output logic              inc_idx_o,
    output logic              inc_j_o,
    output logic              sl_m_o,
    output logic              sl_j2_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [2:0]        dbg_state_o
);

    bf_ctrl_state_e state_q, state_d;

    logic              mode_q, mode_d;
    logic [CntW-1:0]   m_q, m_d;
    logic [CntW-1:0]   grp_q, grp_d;
    logic [LayerW-1:0] lay_q, lay_d;
    logic [CntW-1:0]   bf_rem_q, bf_rem_d;
    logic [CntW-1:0]   grp_rem_q, grp_rem_d;
    logic              grp_first_q, grp_first_d;
    logic              err_q, err_d;

    // Next-layer geometry; a bit shifted out of the MSB is a configuration error.
    logic [CntW-1:0] m_next, grp_next;
    logic            shift_ovf;

    always_comb begin
        if (mode_q) begin
            m_next    = {m_q[CntW-2:0], 1'b0};
            grp_next  = {1'b0, grp_q[CntW-1:1]};
            shift_ovf = m_q[CntW-1];
        end else begin
            m_next    = {1'b0, m_q[CntW-1:1]};
            grp_next  = {grp_q[CntW-2:0], 1'b0};
            shift_ovf = grp_q[CntW-1];
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        m_d         = m_q;
        grp_d       = grp_q;
        lay_d       = lay_q;
        bf_rem_d    = bf_rem_q;
        grp_rem_d   = grp_rem_q;
        grp_first_d = grp_first_q;
        err_d       = err_q;
        bf_valid_o  = 1'b0;
        set_idx_o   = 1'b0;
        inc_idx_o   = 1'b0;
        inc_j_o     = 1'b0;
        sl_m_o      = 1'b0;
        sl_j2_o     = 1'b0;
        done_o      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    mode_d      = mode_i;
                    m_d         = cfg_m_i;
                    grp_d       = cfg_groups_i;
                    lay_d       = cfg_layers_i;
                    grp_first_d = 1'b1;
                    err_d       = 1'b0;
                    if ((cfg_m_i == '0) || (cfg_groups_i == '0) || (cfg_layers_i == '0)) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SET;
                    end
                end
            end

            ST_SET: begin
                if (abort_i) begin
                    state_d = ST_DONE;
                end else begin
                    set_idx_o = 1'b1;
                    bf_rem_d  = m_q - CntW'(1);
                    // The group budget is loaded only on the first group of each layer.
                    if (grp_first_q) begin
                        grp_rem_d   = grp_q - CntW'(1);
                        grp_first_d = 1'b0;
                    end
                    state_d = ST_BF;
                end
            end

            ST_BF: begin
                if (abort_i) begin
                    state_d = ST_DONE;
                end else begin
                    bf_valid_o = 1'b1;
                    if (bf_ready_i) begin
                        if (bf_rem_q != '0) begin
                            inc_idx_o = 1'b1;
                            bf_rem_d  = bf_rem_q - CntW'(1);
                        end else begin
                            inc_j_o = 1'b1;
                            if (grp_rem_q != '0) begin
                                grp_rem_d = grp_rem_q - CntW'(1);
                                state_d   = ST_SET;
                            end else if (lay_q == LayerW'(1)) begin
                                state_d = ST_DONE;
                            end else begin
                                state_d = ST_LAYER;
                            end
                        end
                    end
                end
            end

            ST_LAYER: begin
                if (abort_i) begin
                    state_d = ST_DONE;
                end else begin
                    sl_m_o      = 1'b1;
                    sl_j2_o     = 1'b1;
                    lay_d       = lay_q - LayerW'(1);
                    m_d         = m_next;
                    grp_d       = grp_next;
                    grp_first_d = 1'b1;
                    if ((m_next == '0) || (grp_next == '0) || shift_ovf) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SET;
                    end
                end
            end

            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            mode_q      <= 1'b0;
            m_q         <= '0;
            grp_q       <= '0;
            lay_q       <= '0;
            bf_rem_q    <= '0;
            grp_rem_q   <= '0;
            grp_first_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            m_q         <= m_d;
            grp_q       <= grp_d;
            lay_q       <= lay_d;
            bf_rem_q    <= bf_rem_d;
            grp_rem_q   <= grp_rem_d;
            grp_first_q <= grp_first_d;
            err_q       <= err_d;
        end
    end

    assign busy_o      = (state_q == ST_SET) || (state_q == ST_BF) || (state_q == ST_LAYER);
    assign err_o       = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bf_loop_ctrl.sv
// Self-checking bench for bf_loop_ctrl: a loop-nest reference model fills an expected
// per-cycle event queue, and a negedge monitor pops and compares what the controller does.
module tb_bf_loop_ctrl;
    import bf_loop_ctrl_pkg::*;

    // Event word: busy, set_idx, inc_idx, inc_j, sl_m, sl_j2, bf_valid, done
    localparam logic [7:0] EV_SET   = 8'hC0;
    localparam logic [7:0] EV_INC   = 8'hA2;
    localparam logic [7:0] EV_INCJ  = 8'h92;
    localparam logic [7:0] EV_LAYER = 8'h8C;
    localparam logic [7:0] EV_DONE  = 8'h01;
    localparam logic [7:0] EV_STALL = 8'h82;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       start_i = 1'b0;
    logic       abort_i = 1'b0;
    logic       mode_i = 1'b0;
    logic [7:0] cfg_m_i = '0;
    logic [7:0] cfg_groups_i = '0;
    logic [3:0] cfg_layers_i = '0;
    logic       bf_ready_i = 1'b1;
    logic       bf_valid_o, set_idx_o, inc_idx_o, inc_j_o, sl_m_o, sl_j2_o;
    logic       busy_o, done_o, err_o;
    logic [2:0] dbg_state_o;

    bf_loop_ctrl dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .mode_i       (mode_i),
        .cfg_m_i      (cfg_m_i),
        .cfg_groups_i (cfg_groups_i),
        .cfg_layers_i (cfg_layers_i),
        .bf_valid_o   (bf_valid_o),
        .bf_ready_i   (bf_ready_i),
        .set_idx_o    (set_idx_o),
        .inc_idx_o    (inc_idx_o),
        .inc_j_o      (inc_j_o),
        .sl_m_o       (sl_m_o),
        .sl_j2_o      (sl_j2_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .dbg_state_o  (dbg_state_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [7:0] exp_q[$];
    logic       mon_en = 1'b0;
    int cnt_set, cnt_inc, cnt_j, cnt_sl, cnt_acc, cnt_stall;

    function automatic logic [7:0] ev_word();
        return {busy_o, set_idx_o, inc_idx_o, inc_j_o, sl_m_o, sl_j2_o, bf_valid_o, done_o};
    endfunction

    always @(negedge clk_i) begin
        if (mon_en && rst_ni && (ev_word() != 8'h00)) begin
            cnt_set = cnt_set + int'(set_idx_o);
            cnt_inc = cnt_inc + int'(inc_idx_o);
            cnt_j   = cnt_j + int'(inc_j_o);
            cnt_sl  = cnt_sl + int'(sl_m_o && sl_j2_o);
            cnt_acc = cnt_acc + int'(bf_valid_o && bf_ready_i);
            if (bf_valid_o && !bf_ready_i) begin
                cnt_stall++;
                check("stall_quiet", 32'(ev_word()), 32'(EV_STALL));
            end else if (exp_q.size() == 0) begin
                check("unexpected_event", 32'(ev_word()), 32'h0);
            end else begin
                check("trace", 32'(ev_word()), 32'(exp_q.pop_front()));
            end
        end
    end

    // Reference loop nest: layers -> groups -> butterflies, one event per cycle at full rate.
    task automatic model(input int m, input int g, input int layers, input logic mode,
                         output logic err);
        int cm, cg, nm, ng;
        err = 1'b0;
        if (m == 0 || g == 0 || layers == 0) begin
            err = 1'b1;
            exp_q.push_back(EV_DONE);
            return;
        end
        cm = m;
        cg = g;
        for (int l = 0; l < layers; l++) begin
            for (int gi = 0; gi < cg; gi++) begin
                exp_q.push_back(EV_SET);
                for (int b = 0; b < cm; b++)
                    exp_q.push_back((b == cm - 1) ? EV_INCJ : EV_INC);
            end
            if (l == layers - 1) break;
            exp_q.push_back(EV_LAYER);
            nm = mode ? cm * 2 : cm / 2;
            ng = mode ? cg / 2 : cg * 2;
            if (nm == 0 || ng == 0 || nm > 255 || ng > 255) begin
                err = 1'b1;
                break;
            end
            cm = nm;
            cg = ng;
        end
        exp_q.push_back(EV_DONE);
    endtask

    task automatic run_seq(input int m, input int g, input int layers, input logic mode,
                           input int stall_at, input int stall_len, input bit start_mid,
                           input bit rand_rdy);
        logic exp_err;
        int   stalled = 0;
        bit   fin = 0;
        model(m, g, layers, mode, exp_err);
        cnt_set = 0; cnt_inc = 0; cnt_j = 0; cnt_sl = 0; cnt_acc = 0; cnt_stall = 0;
        mon_en = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b1; mode_i = mode;
        cfg_m_i = 8'(m); cfg_groups_i = 8'(g); cfg_layers_i = 4'(layers);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            if (bf_valid_o && cnt_acc == stall_at && stalled < stall_len) begin
                bf_ready_i = 1'b0;
                stalled++;
            end else begin
                bf_ready_i = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (start_mid && cyc == 3) begin
                start_i = 1'b1; mode_i = ~mode;
                cfg_m_i = 8'd3; cfg_groups_i = 8'd5; cfg_layers_i = 4'd7;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk_i);
            if (done_o) fin = 1;
            @(posedge clk_i); #1;
        end
        bf_ready_i = 1'b1;
        start_i    = 1'b0;
        mon_en     = 1'b0;
        check("done_seen", 32'(fin), 32'd1);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("err_after_run", 32'(err_o), 32'(exp_err));
        check("idle_after_run", 32'(dbg_state_o), 32'(ST_IDLE));
        exp_q.delete();
    endtask

    task automatic step_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i); #1;
        end
    endtask

    initial begin
        // Reset state
        #12;
        check("reset_outputs", 32'(ev_word()), 32'h0);
        check("reset_err", 32'(err_o), 32'h0);
        check("reset_state", 32'(dbg_state_o), 32'(ST_IDLE));
        @(negedge clk_i); rst_ni = 1'b1;
        step_cycles(2);

        // m=2, groups=1, layers=2, NTT: SET BF BF LAYER SET BF SET BF DONE
        run_seq(2, 1, 2, 1'b0, -1, 0, 1'b0, 1'b0);
        check("s1_set_idx", 32'(cnt_set), 32'd3);
        check("s1_inc_idx", 32'(cnt_inc), 32'd1);
        check("s1_inc_j", 32'(cnt_j), 32'd3);
        check("s1_sl", 32'(cnt_sl), 32'd1);
        check("s1_accepts", 32'(cnt_acc), 32'd4);

        // Same run with a 5-cycle stall on the second butterfly and a start pulse while busy
        run_seq(2, 1, 2, 1'b0, 1, 5, 1'b1, 1'b0);
        check("s1s_stall_cycles", 32'(cnt_stall), 32'd5);
        check("s1s_set_idx", 32'(cnt_set), 32'd3);
        check("s1s_accepts", 32'(cnt_acc), 32'd4);

        // INTT: (1,4) (2,2) (4,1)
        run_seq(1, 4, 3, 1'b1, -1, 0, 1'b0, 1'b0);
        check("s2_accepts", 32'(cnt_acc), 32'd12);
        check("s2_set_idx", 32'(cnt_set), 32'd7);
        check("s2_sl", 32'(cnt_sl), 32'd2);

        // Config errors: zero layers, then m shifted to zero
        run_seq(4, 2, 0, 1'b0, -1, 0, 1'b0, 1'b0);
        check("cfg0_strobes", 32'(cnt_set + cnt_inc + cnt_j + cnt_sl), 32'd0);
        run_seq(1, 1, 2, 1'b0, -1, 0, 1'b0, 1'b0);
        // Overflow of groups on a left shift
        run_seq(1, 128, 2, 1'b0, -1, 0, 1'b0, 1'b0);
        // A good run clears err
        run_seq(4, 1, 1, 1'b0, -1, 0, 1'b0, 1'b0);

        // Random configurations with random back-pressure
        for (int r = 0; r < 6; r++) begin
            run_seq(1 << $urandom_range(0, 2), 1 << $urandom_range(0, 2),
                    int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), -1, 0, 1'b0, 1'b1);
        end

        // Abort in BF mid-group
        start_i = 1'b1; mode_i = 1'b0;
        cfg_m_i = 8'd4; cfg_groups_i = 8'd2; cfg_layers_i = 4'd1;
        step_cycles(1);
        start_i = 1'b0;
        step_cycles(2);
        check("abort_pre_state", 32'(dbg_state_o), 32'(ST_BF));
        abort_i = 1'b1;
        #1;
        check("abort_cycle_quiet", 32'(ev_word()), 32'h80);
        step_cycles(1);
        abort_i = 1'b0;
        check("abort_done", 32'(ev_word()), 32'(EV_DONE));
        check("abort_err_kept", 32'(err_o), 32'h0);
        step_cycles(1);
        check("abort_idle", 32'({dbg_state_o, busy_o, done_o}), 32'({ST_IDLE, 2'b00}));

        // Abort alone in IDLE is ignored; start with abort in IDLE starts
        abort_i = 1'b1;
        step_cycles(1);
        check("abort_idle_ignored", 32'(dbg_state_o), 32'(ST_IDLE));
        start_i = 1'b1;
        step_cycles(1);
        start_i = 1'b0; abort_i = 1'b0;
        check("start_beats_abort", 32'(dbg_state_o), 32'(ST_SET));
        for (int i = 0; i < 50 && busy_o; i++) step_cycles(1);
        check("start_abort_finished", 32'(busy_o), 32'h0);
        step_cycles(2);

        // Asynchronous reset mid-BF
        start_i = 1'b1;
        step_cycles(1);
        start_i = 1'b0;
        step_cycles(2);
        check("rst_pre_state", 32'(dbg_state_o), 32'(ST_BF));
        #2 rst_ni = 1'b0;
        #1;
        check("rst_mid_outputs", 32'({ev_word(), err_o}), 32'h0);
        check("rst_mid_state", 32'(dbg_state_o), 32'(ST_IDLE));
        @(negedge clk_i); rst_ni = 1'b1;
        step_cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
